// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and the bit positions of the
// status/data word seen by the CPU. The transmitter uses the same package.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_state_e;

  // Status word layout: {valid, overrun, ferr, 5'b0, data[7:0]}
  localparam int unsigned VALID_BIT = 15;
  localparam int unsigned OVR_BIT   = 14;
  localparam int unsigned FERR_BIT  = 13;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset; both flops reset to 1 (line idle level)
//   d_i    : asynchronous input
//   q_o    : synchronized output
module sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_io.sv
// Memory-mapped UART receiver for the IO3 slot (8N1, LSB first).
//   clk   : system clock
//   reset : asynchronous active-low reset
//   rx    : asynchronous serial line, idles high
//   in    : CPU write data, ignored (a write only acknowledges)
//   load  : CPU write strobe for this slot; clears valid/overrun/ferr
//   out   : {valid, overrun, ferr, 5'b0, data[7:0]}; valid makes the word negative
module uart_rx_io
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic [15:0] in,
  input  logic        load,
  output logic [15:0] out
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntFull = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);

  logic rx_s;
  logic unused_in;

  uart_state_e     state_q, state_d;
  logic            arm_q, arm_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            commit_q, commit_d;
  logic            stop_q, stop_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ovr_q, ovr_d;
  logic            ferr_q, ferr_d;

  assign unused_in = ^in;

  sync2 u_sync_rx (
    .clk_i  (clk),
    .rst_ni (reset),
    .d_i    (rx),
    .q_o    (rx_s)
  );

  always_comb begin
    state_d   = state_q;
    // ARM records that the line has been seen idle since the last stop bit.
    arm_d     = arm_q | rx_s;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    commit_d  = 1'b0;
    stop_d    = stop_q;

    unique case (state_q)
      StIdle: begin
        if (arm_q && !rx_s) begin
          state_d = StStart;
          cnt_d   = CntHalf;
        end
      end
      StStart: begin
        if (cnt_q == '0) begin
          if (rx_s) begin
            state_d = StIdle;  // false start
          end else begin
            state_d   = StData;
            cnt_d     = CntFull;
            bit_idx_d = 3'd0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StData: begin
        if (cnt_q == '0) begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = CntFull;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;  // index saturates at 7
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StStop: begin
        if (cnt_q == '0) begin
          commit_d = 1'b1;
          stop_d   = rx_s;
          state_d  = StIdle;
          arm_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Commit takes priority over an acknowledge in the same cycle.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    ferr_d  = ferr_q;
    if (commit_q) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      ferr_d  = ~stop_q;
      ovr_d   = valid_q & ~load;
    end else if (load) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
      ferr_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      arm_q     <= 1'b0;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      commit_q  <= 1'b0;
      stop_q    <= 1'b0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      arm_q     <= arm_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      commit_q  <= commit_d;
      stop_q    <= stop_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    out            = 16'h0000;
    out[VALID_BIT] = valid_q;
    out[OVR_BIT]   = ovr_q;
    out[FERR_BIT]  = ferr_q;
    out[7:0]       = data_q;
  end

endmodule
